cplx_mult_sched: RTL and testbench
==================================

Name: cplx_mult_sched

Overview:
- Shares one cplx_mult instance between N_REQ requesters, e.g. FFT butterfly lanes.
- Round-robin arbitrates requests and registers operands into the multiplier.
- Enforces the multiplier's 2-cycle initiation interval.
- Tracks the requester ID of each in-flight product through a fixed-latency tag pipeline and routes each 48-bit result back to its owner. Sits between the butterfly lanes and the cplx_mult instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal ceil(log2(N_REQ)).
- MULT_LAT, 3, cycles from o_u1_mult_valid high to i_u1_mult_valid_out high.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  N_REQ  per-requester request valid.
- o_req_ready  out  N_REQ  per-requester ready, one-hot or zero.
- i_req_data  in  N_REQ*72  per requester {AR,AI,BR,BI}, each signed 18 bits, AR in MSBs; requester k in bits [72k+71:72k].
- o_u1_mult_valid  out  1  to cplx_mult i_u1_valid_in.
- o_s18_AR, o_s18_AI, o_s18_BR, o_s18_BI  out  18 each  operands to cplx_mult.
- i_u1_mult_valid_out  in  1  from cplx_mult o_u1_valid_out.
- i_s48_R, i_s48_I  in  48 each  product from cplx_mult.
- o_rsp_valid  out  N_REQ  one-hot result strobe.
- o_s48_rsp_R, o_s48_rsp_I  out  48 each  shared result bus.
- o_u1_idle  out  1  no accepted request in flight.
- o_u1_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n low) clears everything:
  - all outputs 0, except o_u1_idle=1;
  - state=ACCEPT, rr pointer=0, tag pipeline cleared, in-flight count=0, o_u1_err=0.
- States: ACCEPT, COOL.
  - ACCEPT: the grant goes to the first k with i_req_valid[k]=1, searching k = ptr, ptr+1, … mod N_REQ.
    - o_req_ready[grant]=1 (combinational); all other ready bits 0.
    - If no request, all ready bits are 0 and the state holds.
  - Handshake = valid & ready on the granted lane. On handshake:
    - register that lane's four operands;
    - o_u1_mult_valid<=1;
    - push {1,grant} into tag stage 0;
    - ptr<=grant+1 mod N_REQ;
    - state<=COOL.
  - COOL: all ready bits 0.
    - o_u1_mult_valid is 1 this cycle, then returns to 0.
    - Operands hold their values through COOL.
    - Next state is ACCEPT unconditionally.
    - Sustained throughput is one request per 2 cycles.
  - Requesters may drop i_req_valid before a handshake; no grant is locked.
- Tag pipeline: MULT_LAT stages of {v, id}, shifting every cycle.
  - Stage 0 is loaded in the cycle o_u1_mult_valid=1 (v=0 otherwise).
  - The last stage is aligned with i_u1_mult_valid_out.
- Response, one cycle after i_u1_mult_valid_out=1 with last-stage v=1:
  - o_rsp_valid[id]=1 for one cycle;
  - o_s48_rsp_R/I = registered i_s48_R/I.
  - Otherwise o_rsp_valid=0 and the bus holds its last value.
- Latency: handshake at cycle t -> o_u1_mult_valid at t+1 -> result at t+4 -> o_rsp_valid at t+5.
- Error, sticky until reset: o_u1_err<=1 in either case:
  - i_u1_mult_valid_out=1 while last-stage v=0 (no response is issued);
  - last-stage v=1 while i_u1_mult_valid_out=0.
- In-flight counter (width ID_W+2):
  - +1 on handshake, -1 on response; both in the same cycle means no change.
  - o_u1_idle = (count==0) and state==ACCEPT.
- No backpressure on responses: requesters must always sink o_rsp_valid.
- Reset mid-operation discards all in-flight tags; late multiplier outputs after reset are ignored without setting o_u1_err.
  - Requirement: cplx_mult shares rst_n.

Test Plan:
1. Reset, then a single request: lane 2, AR=3, AI=4, BR=5, BI=-2 at t -> o_u1_mult_valid at t+1 with the same operands; o_rsp_valid=4'b0100 at t+5 with R=23, I=14; o_u1_idle returns to 1.
2. All four lanes valid continuously, ptr=0 -> grants 0,1,2,3,0 at t, t+2, t+4, t+6, t+8; ready is never high in COOL cycles; responses appear in the same order at t+5, t+7, …
3. Lanes 1 and 3 only, ptr=2 -> grant 3 first, then 1; lane 3's result is routed only to o_rsp_valid[3].
4. Drive i_u1_mult_valid_out=1 with no request outstanding -> o_u1_err=1 from the next cycle and remains 1; o_rsp_valid stays 0.
5. Assert rst_n low asynchronously two cycles after a handshake -> all outputs clear immediately; no o_rsp_valid afterwards; o_u1_err stays 0.
6. Back-to-back stream of 16 random operands -> every response matches the reference complex product bit-exactly and is delivered on the correct lane; o_u1_err stays 0.

Source files
------------

// File: rtl/cplx_mult_sched.sv
// Shares one cplx_mult between N_REQ lanes: round-robin grant, 2-cycle issue, tag-tracked result return.
// Latency: handshake at t -> operands valid at t+1 -> o_rsp_valid at t+2+MULT_LAT.
// Backpressure: at most one ready bit, never in the cooldown cycle; responses cannot be stalled.
module cplx_mult_sched #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MULT_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*72-1:0]       i_req_data,
    output logic                      o_u1_mult_valid,
    output logic signed [17:0]        o_s18_AR,
    output logic signed [17:0]        o_s18_AI,
    output logic signed [17:0]        o_s18_BR,
    output logic signed [17:0]        o_s18_BI,
    input  logic                      i_u1_mult_valid_out,
    input  logic signed [47:0]        i_s48_R,
    input  logic signed [47:0]        i_s48_I,
    output logic [N_REQ-1:0]          o_rsp_valid,
    output logic signed [47:0]        o_s48_rsp_R,
    output logic signed [47:0]        o_s48_rsp_I,
    output logic                      o_u1_idle,
    output logic                      o_u1_err
);

    localparam int CNT_W = ID_W + 2;
    localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    typedef enum logic {ACCEPT, COOL} state_t;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic signed [17:0] ar;
        logic signed [17:0] ai;
        logic signed [17:0] br;
        logic signed [17:0] bi;
    } opnd_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    opnd_t                  opnd_q, opnd_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   mult_vld_q, mult_vld_d;
    tag_t [MULT_LAT-1:0]    tag_q, tag_d;
    logic [N_REQ-1:0]       rsp_vld_q, rsp_vld_d;
    logic signed [47:0]     rsp_r_q, rsp_r_d;
    logic signed [47:0]     rsp_i_q, rsp_i_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   gnt_found;
    logic [ID_W-1:0]        gnt_id;
    logic [N_REQ-1:0]       rdy;
    logic                   hs;
    logic                   rsp_fire;
    opnd_t                  sel_opnd;
    tag_t                   last_tag;

    // Search lanes starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        logic [ID_W:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (!gnt_found && i_req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        rdy = '0;
        if (state_q == ACCEPT && gnt_found) begin
            rdy[gnt_id] = 1'b1;
        end
    end

    assign hs       = (state_q == ACCEPT) && gnt_found;
    assign sel_opnd = i_req_data[int'(gnt_id) * 72 +: 72];
    assign last_tag = tag_q[MULT_LAT-1];
    assign rsp_fire = last_tag.v && i_u1_mult_valid_out;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        opnd_d     = opnd_q;
        id_d       = id_q;
        mult_vld_d = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (hs) begin
                    opnd_d     = sel_opnd;
                    id_d       = gnt_id;
                    mult_vld_d = 1'b1;
                    ptr_d      = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
                    state_d    = COOL;
                end
            end
            COOL: begin
                state_d = ACCEPT;
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    // Stage 0 captures the issue cycle so the last stage lines up with the multiplier output.
    always_comb begin
        tag_d       = tag_q;
        tag_d[0].v  = mult_vld_q;
        tag_d[0].id = id_q;
        for (int i = 1; i < MULT_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        rsp_vld_d = '0;
        rsp_r_d   = rsp_r_q;
        rsp_i_d   = rsp_i_q;
        if (rsp_fire) begin
            rsp_vld_d[last_tag.id] = 1'b1;
            rsp_r_d                = i_s48_R;
            rsp_i_d                = i_s48_I;
        end
        err_d = err_q | (last_tag.v ^ i_u1_mult_valid_out);
        case ({hs, rsp_fire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCEPT;
            ptr_q      <= '0;
            opnd_q     <= '0;
            id_q       <= '0;
            mult_vld_q <= 1'b0;
            tag_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_r_q    <= '0;
            rsp_i_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            opnd_q     <= opnd_d;
            id_q       <= id_d;
            mult_vld_q <= mult_vld_d;
            tag_q      <= tag_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_r_q    <= rsp_r_d;
            rsp_i_q    <= rsp_i_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign o_req_ready     = rdy;
    assign o_u1_mult_valid = mult_vld_q;
    assign o_s18_AR        = opnd_q.ar;
    assign o_s18_AI        = opnd_q.ai;
    assign o_s18_BR        = opnd_q.br;
    assign o_s18_BI        = opnd_q.bi;
    assign o_rsp_valid     = rsp_vld_q;
    assign o_s48_rsp_R     = rsp_r_q;
    assign o_s48_rsp_I     = rsp_i_q;
    assign o_u1_idle       = (cnt_q == '0) && (state_q == ACCEPT);
    assign o_u1_err        = err_q;

endmodule

// File: tb/tb_cplx_mult_sched.sv
// Bench for cplx_mult_sched with a behavioural 3-stage complex multiplier and a response scoreboard.
module tb_cplx_mult_sched;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int MULT_LAT = 3;

    logic                  clk;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*72-1:0]   req_data;
    logic                  mult_valid;
    logic signed [17:0]    ar, ai, br, bi;
    logic                  mult_vout;
    logic signed [47:0]    mult_r, mult_i;
    logic [N_REQ-1:0]      rsp_valid;
    logic signed [47:0]    rsp_r, rsp_i;
    logic                  idle, err;
    logic                  inj;

    typedef struct {
        int                 lane;
        logic signed [47:0] r;
        logic signed [47:0] i;
        int                 due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    cplx_mult_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .MULT_LAT(MULT_LAT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_req_valid         (req_valid),
        .o_req_ready         (req_ready),
        .i_req_data          (req_data),
        .o_u1_mult_valid     (mult_valid),
        .o_s18_AR            (ar),
        .o_s18_AI            (ai),
        .o_s18_BR            (br),
        .o_s18_BI            (bi),
        .i_u1_mult_valid_out (mult_vout),
        .i_s48_R             (mult_r),
        .i_s48_I             (mult_i),
        .o_rsp_valid         (rsp_valid),
        .o_s48_rsp_R         (rsp_r),
        .o_s48_rsp_I         (rsp_i),
        .o_u1_idle           (idle),
        .o_u1_err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmul(input logic signed [17:0] a_r, a_i, b_r, b_i,
                                 output logic signed [47:0] p_r, p_i);
        longint tr, ti;
        tr  = longint'(a_r) * longint'(b_r) - longint'(a_i) * longint'(b_i);
        ti  = longint'(a_r) * longint'(b_i) + longint'(a_i) * longint'(b_r);
        p_r = tr[47:0];
        p_i = ti[47:0];
    endfunction

    // External multiplier stand-in: MULT_LAT cycles, shares rst_n with the scheduler.
    logic [MULT_LAT-1:0]  mv;
    logic signed [47:0]   mr [MULT_LAT];
    logic signed [47:0]   mi [MULT_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
        end else begin
            logic signed [47:0] pr, pi;
            cmul(ar, ai, br, bi, pr, pi);
            mv[0] <= mult_valid;
            mr[0] <= pr;
            mi[0] <= pi;
            for (int k = 1; k < MULT_LAT; k++) begin
                mv[k] <= mv[k-1];
                mr[k] <= mr[k-1];
                mi[k] <= mi[k-1];
            end
        end
    end
    assign mult_vout = mv[MULT_LAT-1] | inj;
    assign mult_r    = mr[MULT_LAT-1];
    assign mult_i    = mi[MULT_LAT-1];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every response strobe and flags missing ones.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected valid=%b cycle=%0d", rsp_valid, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_lane", rsp_valid, 64'(1) << e.lane);
                    check("rsp_R", rsp_r, e.r);
                    check("rsp_I", rsp_i, e.i);
                    check("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing lane=%0d due=%0d now=%0d", e.lane, e.due, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        inj       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_lane(input int lane, input logic signed [17:0] a_r, a_i, b_r, b_i);
        req_data[lane*72 +: 72] = {a_r, a_i, b_r, b_i};
    endtask

    task automatic push(input int lane, input logic signed [47:0] r, i, input int due);
        exp_t e;
        e.lane = lane;
        e.r    = r;
        e.i    = i;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_empty", sb.size(), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [3:0] er;

        // Reset state
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        inj       = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_mult_valid", mult_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_idle", idle, 1);
        check("rst_err", err, 0);
        check("rst_AR", ar, 0);
        check("rst_rsp_R", rsp_r, 0);
        apply_reset();

        // 1: single request on lane 2
        set_lane(2, 3, 4, 5, -2);
        req_valid = 4'b0100;
        t = cyc;
        push(2, 23, 14, t + 5);
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_mult_valid", mult_valid, 1);
        check("t1_AR", ar, 3);
        check("t1_AI", ai, 4);
        check("t1_BR", br, 5);
        check("t1_BI", bi, -2);
        check("t1_cool_ready", req_ready, 0);
        check("t1_busy", idle, 0);
        tick();
        @(negedge clk);
        check("t1_mult_valid_drop", mult_valid, 0);
        check("t1_AR_hold", ar, 3);
        wait_drain();
        @(negedge clk);
        check("t1_idle", idle, 1);
        tick();

        // 2: all lanes valid, pointer at 0
        apply_reset();
        set_lane(0, 1, 2, 3, 4);
        set_lane(1, -7, 5, 2, -3);
        set_lane(2, 100, -50, -20, 8);
        set_lane(3, 131071, 0, -131072, 0);
        req_valid = 4'b1111;
        t = cyc;
        push(0, -5, 10, t + 5);
        push(1, 1, 31, t + 7);
        push(2, -1600, 1800, t + 9);
        push(3, -48'sd17179738112, 0, t + 11);
        push(0, -5, 10, t + 13);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            er = 4'b0001 << ((k / 2) % 4);
            if (k % 2 != 0) er = 4'b0000;
            check("t2_ready", req_ready, er);
            tick();
            if (k == 8) req_valid = '0;
        end
        wait_drain();

        // 3: lanes 1 and 3 with pointer at 2
        apply_reset();
        set_lane(1, 2, 0, 0, 1);
        req_valid = 4'b0010;
        t = cyc;
        push(1, 0, 2, t + 5);
        tick();
        req_valid = '0;
        wait_drain();
        set_lane(1, -131072, -131072, -131072, -131072);
        set_lane(3, 0, -1, 0, -1);
        req_valid = 4'b1010;
        t = cyc;
        push(3, -1, 0, t + 5);
        push(1, 0, 48'sd34359738368, t + 7);
        @(negedge clk);
        check("t3_ready_first", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        check("t3_ready_cool", req_ready, 0);
        tick();
        @(negedge clk);
        check("t3_ready_second", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_drain();

        // 4: spurious multiplier output
        apply_reset();
        inj = 1'b1;
        @(negedge clk);
        check("t4_err_before", err, 0);
        tick();
        inj = 1'b0;
        @(negedge clk);
        check("t4_err_set", err, 1);
        repeat (5) tick();
        @(negedge clk);
        check("t4_err_sticky", err, 1);
        check("t4_no_rsp", rsp_valid, 0);
        tick();

        // 5: asynchronous reset two cycles after a handshake
        apply_reset();
        set_lane(0, 7, 8, 9, 10);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t5_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        check("t5_busy", idle, 0);
        check("t5_AR_held", ar, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_idle_async", idle, 1);
        check("t5_AR_async", ar, 0);
        check("t5_mult_valid_async", mult_valid, 0);
        check("t5_rsp_async", rsp_valid, 0);
        check("t5_err_async", err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) tick();
        check("t5_err_after", err, 0);
        check("t5_idle_after", idle, 1);

        // 6: back-to-back stream of 16 random operand sets
        for (int n = 0; n < 16; n++) begin
            int lane;
            logic signed [17:0] a_r, a_i, b_r, b_i;
            logic signed [47:0] p_r, p_i;
            logic got;
            lane = $urandom_range(0, N_REQ - 1);
            a_r  = 18'($urandom);
            a_i  = 18'($urandom);
            b_r  = 18'($urandom);
            b_i  = 18'($urandom);
            if (n == 0) begin
                a_r = -131072; a_i = -131072; b_r = 131071; b_i = -131072;
            end
            cmul(a_r, a_i, b_r, b_i, p_r, p_i);
            set_lane(lane, a_r, a_i, b_r, b_i);
            req_valid = '0;
            req_valid[lane] = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge clk);
                if (req_ready[lane]) begin
                    got = 1'b1;
                    push(lane, p_r, p_i, cyc + 5);
                end
                tick();
            end
            if (!got) check("t6_handshake_timeout", 0, 1);
        end
        req_valid = '0;
        wait_drain();
        check("t6_err", err, 0);
        check("t6_idle", idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
